// File: rtl/cordic_sincos.sv
// ---------------------------------------------------------------------------
// cordic_sincos
//
// Iterative CORDIC rotator. It returns the cosine and the sine of an unsigned
// phase angle and performs one micro-rotation per clock. A request is taken
// with a start/ready handshake, and the results are flagged by a one-cycle
// done pulse.
//
// Ports
//   clk      : clock, all logic on the rising edge
//   reset    : synchronous, active-low reset
//   start    : request, accepted when start && ready at a rising edge
//   angle    : unsigned phase, 2^WIDTH == 2*pi
//   ready    : idle and able to accept a request
//   done     : one-cycle pulse, cos_out/sin_out valid
//   cos_out  : signed cosine, Q2.(WIDTH-2)
//   sin_out  : signed sine,   Q2.(WIDTH-2)
//
// Build option
//   CORDIC_SINCOS_ROUND_EN : round half-up (saturating) when the two guard
//                            bits are dropped. Without it they are truncated.
// ---------------------------------------------------------------------------
module cordic_sincos #(
    parameter int WIDTH      = 32,
    parameter int ITERATIONS = WIDTH - 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] angle,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] cos_out,
    output logic [WIDTH-1:0] sin_out
);

    localparam int DW          = WIDTH + 2;
    localparam int CW          = $clog2(ITERATIONS);
    localparam int SCALE_SHIFT = 32 - WIDTH;

    // Constants are tabulated for a 32-bit angle. They are rescaled to WIDTH
    // with round-to-nearest: floor((floor(2v/2^s) + 1) / 2).
    function automatic longint scaleFrom32(input longint v);
        return (((v <<< 1) >>> SCALE_SHIFT) + 64'sd1) >>> 1;
    endfunction

    // round(atan(2^-i) * 2^32 / (2*pi))
    function automatic longint atanQ32(input int i);
        case (i)
            0:  atanQ32 = 64'd536870912;
            1:  atanQ32 = 64'd316933406;
            2:  atanQ32 = 64'd167458907;
            3:  atanQ32 = 64'd85004756;
            4:  atanQ32 = 64'd42667331;
            5:  atanQ32 = 64'd21354465;
            6:  atanQ32 = 64'd10679838;
            7:  atanQ32 = 64'd5340245;
            8:  atanQ32 = 64'd2670163;
            9:  atanQ32 = 64'd1335087;
            10: atanQ32 = 64'd667544;
            11: atanQ32 = 64'd333772;
            12: atanQ32 = 64'd166886;
            13: atanQ32 = 64'd83443;
            14: atanQ32 = 64'd41722;
            15: atanQ32 = 64'd20861;
            16: atanQ32 = 64'd10430;
            17: atanQ32 = 64'd5215;
            18: atanQ32 = 64'd2608;
            19: atanQ32 = 64'd1304;
            20: atanQ32 = 64'd652;
            21: atanQ32 = 64'd326;
            22: atanQ32 = 64'd163;
            23: atanQ32 = 64'd81;
            24: atanQ32 = 64'd41;
            25: atanQ32 = 64'd20;
            26: atanQ32 = 64'd10;
            27: atanQ32 = 64'd5;
            28: atanQ32 = 64'd3;
            29: atanQ32 = 64'd1;
            default: atanQ32 = 64'd0;
        endcase
    endfunction

    // CORDIC gain K in Q2.(WIDTH-2). x and y carry the two guard bits below
    // the output LSB, so the start value sits two places higher.
    localparam longint               GAIN_Q = scaleFrom32(64'd652032874);
    localparam logic signed [DW-1:0] X_INIT = DW'(GAIN_Q * 4);

`ifdef CORDIC_SINCOS_ROUND_EN
    localparam logic signed [DW-1:0] ROUND_HALF = DW'(2);
    localparam logic signed [DW-1:0] MAX_POS    = {3'b000, {(WIDTH-1){1'b1}}};
`endif

    typedef enum logic [1:0] {S_IDLE, S_ROTATE, S_FINISH} state_t;

    state_t               r_state;
    logic [CW-1:0]        r_iter;
    logic signed [DW-1:0] r_x, r_y, r_z;
    logic                 r_negate;

    logic signed [DW-1:0] w_atanTable [ITERATIONS];

    for (genvar g = 0; g < ITERATIONS; g++) begin : g_atan
        assign w_atanTable[g] = DW'(scaleFrom32(atanQ32(g)));
    end

    // Quadrant reduction. When the top two bits differ, the angle lies in
    // [pi/2, 3pi/2). Flipping the MSB moves it by pi into [-pi/2, pi/2).
    // The result is negated at the end to compensate.
    logic                 w_quadFlip;
    logic [WIDTH-1:0]     w_reduced;
    logic signed [DW-1:0] w_zInit;

    assign w_quadFlip = angle[WIDTH-1] ^ angle[WIDTH-2];
    assign w_reduced  = {angle[WIDTH-1] ^ w_quadFlip, angle[WIDTH-2:0]};
    assign w_zInit    = {{2{w_reduced[WIDTH-1]}}, w_reduced};

    // One micro-rotation. It rotates toward z == 0; z >= 0 rotates positively.
    logic signed [DW-1:0] w_xShift, w_yShift, w_atan;
    logic signed [DW-1:0] w_xNext, w_yNext, w_zNext;

    always_comb begin
        w_xShift = r_x >>> r_iter;
        w_yShift = r_y >>> r_iter;
        w_atan   = w_atanTable[r_iter];
        if (r_z[DW-1]) begin
            w_xNext = r_x + w_yShift;
            w_yNext = r_y - w_xShift;
            w_zNext = r_z + w_atan;
        end else begin
            w_xNext = r_x - w_yShift;
            w_yNext = r_y + w_xShift;
            w_zNext = r_z - w_atan;
        end
    end

    // Drop the two guard bits to return to WIDTH bits.
    function automatic logic [WIDTH-1:0] reduceGuard(input logic signed [DW-1:0] v);
`ifdef CORDIC_SINCOS_ROUND_EN
        logic signed [DW-1:0] t;
        t = (v + ROUND_HALF) >>> 2;
        if (t > MAX_POS) begin
            t = MAX_POS;
        end
        return WIDTH'(t);
`else
        return WIDTH'(v >>> 2);
`endif
    endfunction

    logic signed [DW-1:0] w_xFinal, w_yFinal;
    logic [WIDTH-1:0]     w_cosOut, w_sinOut;

    assign w_xFinal = r_negate ? -r_x : r_x;
    assign w_yFinal = r_negate ? -r_y : r_y;
    assign w_cosOut = reduceGuard(w_xFinal);
    assign w_sinOut = reduceGuard(w_yFinal);

    // Control and datapath registers.
    // IDLE latches the reduced angle. ROTATE runs ITERATIONS steps.
    // FINISH publishes the results and raises done for one cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_iter   <= '0;
            r_x      <= '0;
            r_y      <= '0;
            r_z      <= '0;
            r_negate <= 1'b0;
            ready    <= 1'b1;
            done     <= 1'b0;
            cos_out  <= '0;
            sin_out  <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start && ready) begin
                        r_x      <= X_INIT;
                        r_y      <= '0;
                        r_z      <= w_zInit;
                        r_negate <= w_quadFlip;
                        r_iter   <= '0;
                        ready    <= 1'b0;
                        r_state  <= S_ROTATE;
                    end
                end
                S_ROTATE: begin
                    r_x <= w_xNext;
                    r_y <= w_yNext;
                    r_z <= w_zNext;
                    if (r_iter == CW'(ITERATIONS - 1)) begin
                        r_state <= S_FINISH;
                    end else begin
                        r_iter <= r_iter + CW'(1);
                    end
                end
                S_FINISH: begin
                    cos_out <= w_cosOut;
                    sin_out <= w_sinOut;
                    done    <= 1'b1;
                    ready   <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    ready   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_sincos.sv
// ---------------------------------------------------------------------------
// tb_cordic_sincos
//
// Self-checking bench for cordic_sincos at WIDTH=32. Expected cosine and
// sine come from real-valued $cos/$sin on the phase, scaled to Q2.30. They
// are compared within the stated accuracy bound. The bench also checks
// latency, handshake behaviour, stability of held results and mid-operation
// reset.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_cordic_sincos;

    localparam int     W      = 32;
    localparam int     ITER   = W - 2;
    localparam int     LAT    = ITER + 2;
    localparam longint TOL    = 8;
    localparam int     BOUND  = 200;
    localparam real    PI     = 3.14159265358979323846;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] angle;
    logic         ready;
    logic         done;
    logic [W-1:0] cosOut;
    logic [W-1:0] sinOut;

    int checkCount = 0;
    int errorCount = 0;

    cordic_sincos #(.WIDTH(W), .ITERATIONS(ITER)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .angle   (angle),
        .ready   (ready),
        .done    (done),
        .cos_out (cosOut),
        .sin_out (sinOut)
    );

    always #5 clk = ~clk;

    // Reference: the ideal trig value in Q2.(W-2), rounded to nearest.
    function automatic longint modelCos(input logic [W-1:0] a);
        real th;
        th = real'(a) * 2.0 * PI / (2.0 ** W);
        return longint'($cos(th) * (2.0 ** (W - 2)));
    endfunction

    function automatic longint modelSin(input logic [W-1:0] a);
        real th;
        th = real'(a) * 2.0 * PI / (2.0 ** W);
        return longint'($sin(th) * (2.0 ** (W - 2)));
    endfunction

    function automatic longint sval(input logic [W-1:0] v);
        return longint'($signed(v));
    endfunction

    // Single comparison point: |observed - expected| must be within tol.
    task automatic checkOutput(input string tag, input longint observed,
                               input longint expected, input longint tol);
        longint diff;
        checkCount++;
        diff = observed - expected;
        if (diff < 0) diff = -diff;
        if (diff > tol) begin
            errorCount++;
            $display("[TB] FAIL %s observed %0d expected %0d (tol %0d)",
                     tag, observed, expected, tol);
        end
    endtask

    // Pulses start for one cycle with angle a. Waits (bounded) for done and
    // returns the cycle count, with the accepting edge counted as cycle 1.
    task automatic applyStimulus(input logic [W-1:0] a, output int lat);
        @(negedge clk);
        angle = a;
        start = 1'b1;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        start = 1'b0;
        while (!done && lat < BOUND) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic runAndCheck(input string tag, input logic [W-1:0] a);
        int lat;
        applyStimulus(a, lat);
        checkOutput({tag, ".lat"}, lat, LAT, 0);
        checkOutput({tag, ".cos"}, sval(cosOut), modelCos(a), TOL);
        checkOutput({tag, ".sin"}, sval(sinOut), modelSin(a), TOL);
        @(negedge clk);
        checkOutput({tag, ".donePulse"}, done, 0, 0);
        checkOutput({tag, ".hold"}, sval(cosOut), modelCos(a), TOL);
    endtask

    // Watchdog, in case a wait is ever left unbounded.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog observed timeout expected completion");
        $fatal(1, "[TB] simulation timeout");
    end

    initial begin
        logic [W-1:0] a, b;
        int lat, gap, readyHigh, doneSeen;

        reset = 1'b0;
        start = 1'b0;
        angle = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("rst.ready", ready, 1, 0);
        checkOutput("rst.done", done, 0, 0);
        checkOutput("rst.cos", sval(cosOut), 0, 0);
        checkOutput("rst.sin", sval(sinOut), 0, 0);

        // Directed angles, including quadrant edges.
        runAndCheck("ang0", 32'd0);
        runAndCheck("angPi", 32'h8000_0000);
        runAndCheck("ang2pi3", 32'd1431655765);
        runAndCheck("ang4pi3", 32'd2863311531);
        runAndCheck("angPi2", 32'h4000_0000);
        runAndCheck("ang3pi2", 32'hC000_0000);
        runAndCheck("angMax2", 32'hFFFF_FFFE);
        checkOutput("angMax2.sinRange",
                    longint'((sval(sinOut) <= 0) && (sval(sinOut) >= -8)), 1, 0);
        runAndCheck("angMax1", 32'hFFFF_FFFF);

        // Start and angle changes while busy must be ignored.
        a = 32'h1234_5678;
        b = 32'hA000_0000;
        @(negedge clk);
        angle = a;
        start = 1'b1;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        start = 1'b0;
        angle = b;
        checkOutput("busy.ready", ready, 0, 0);
        while (!done && lat < BOUND) begin
            if (lat == 5) begin
                start = 1'b1;
                angle = b;
            end else if (lat == 6) begin
                start = 1'b0;
                angle = $urandom;
            end
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        checkOutput("busy.lat", lat, LAT, 0);
        checkOutput("busy.cos", sval(cosOut), modelCos(a), TOL);
        checkOutput("busy.sin", sval(sinOut), modelSin(a), TOL);

        // Start held high: back-to-back results, one ready cycle in between.
        a = 32'h2AAA_0000;
        @(negedge clk);
        angle = a;
        start = 1'b1;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        while (!done && lat < BOUND) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        checkOutput("b2b.lat", lat, LAT, 0);
        checkOutput("b2b.cos1", sval(cosOut), modelCos(a), TOL);
        readyHigh = 0;
        gap = 0;
        while (gap < BOUND) begin
            if (ready) readyHigh++;
            @(posedge clk);
            gap++;
            @(negedge clk);
            if (gap == 1) start = 1'b0;
            if (done) break;
        end
        checkOutput("b2b.gap", gap, LAT, 0);
        checkOutput("b2b.readyCycles", readyHigh, 1, 0);
        checkOutput("b2b.cos2", sval(cosOut), modelCos(a), TOL);
        checkOutput("b2b.sin2", sval(sinOut), modelSin(a), TOL);

        // Reset for one cycle at iteration 10 aborts the request.
        @(negedge clk);
        angle = 32'h3000_0000;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        checkOutput("abort.ready", ready, 1, 0);
        checkOutput("abort.done", done, 0, 0);
        checkOutput("abort.cos", sval(cosOut), 0, 0);
        checkOutput("abort.sin", sval(sinOut), 0, 0);
        doneSeen = 0;
        repeat (LAT + 8) begin
            @(negedge clk);
            if (done) doneSeen++;
        end
        checkOutput("abort.noDone", doneSeen, 0, 0);
        runAndCheck("postAbort", 32'h6543_2100);

        // Random phases against the trig reference.
        for (int i = 0; i < 20; i++) begin
            runAndCheck("rand", 32'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
